// File: rtl/cc_lane_shift_scheduler.sv
// ---------------------------------------------------------------------------
// cc_lane_shift_scheduler
//
// Shares one external combinational shift comparator between LANES lane
// counters of the Frogger lane engine. One lane is visited per scanning
// cycle. The visited lane's count and period are presented to the
// comparator, and its active-low equal result is sampled in the same cycle.
// On a match the lane's count restarts and a one-cycle registered shift
// strobe is raised for that lane.
//
// Ports
//   CC_LANESCHED_CLOCK_50         in   system clock, rising edge
//   CC_LANESCHED_RESET_InHigh     in   synchronous active-high reset
//   CC_LANESCHED_run_InHigh       in   1 = scan lanes, 0 = pause
//   CC_LANESCHED_clear_InHigh     in   restart: zero counts, slot to 0
//   CC_LANESCHED_cfgWrite_InHigh  in   period write strobe
//   CC_LANESCHED_cfgLane_InBUS    in   lane addressed by the write
//   CC_LANESCHED_cfgPeriod_InBUS  in   new period (0 disables the lane)
//   CC_LANESCHED_cmpData_OutBUS   out  count[slot] to comparator data input
//   CC_LANESCHED_cmpValue_OutBUS  out  period[slot] to comparator SHIFT_VALUE
//   CC_LANESCHED_cmpEqual_InLow   in   comparator result, 0 = equal
//   CC_LANESCHED_shift_OutBUS     out  per-lane one-cycle shift strobes
//   CC_LANESCHED_slot_OutBUS      out  lane currently being compared
// ---------------------------------------------------------------------------
module cc_lane_shift_scheduler #(
  parameter int LANES     = 4,
  parameter int DATAWIDTH = 23,
  localparam int SW       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                 CC_LANESCHED_CLOCK_50,
  input  logic                 CC_LANESCHED_RESET_InHigh,
  input  logic                 CC_LANESCHED_run_InHigh,
  input  logic                 CC_LANESCHED_clear_InHigh,
  input  logic                 CC_LANESCHED_cfgWrite_InHigh,
  input  logic [SW-1:0]        CC_LANESCHED_cfgLane_InBUS,
  input  logic [DATAWIDTH-1:0] CC_LANESCHED_cfgPeriod_InBUS,
  output logic [DATAWIDTH-1:0] CC_LANESCHED_cmpData_OutBUS,
  output logic [DATAWIDTH-1:0] CC_LANESCHED_cmpValue_OutBUS,
  input  logic                 CC_LANESCHED_cmpEqual_InLow,
  output logic [LANES-1:0]     CC_LANESCHED_shift_OutBUS,
  output logic [SW-1:0]        CC_LANESCHED_slot_OutBUS
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] count_q  [LANES];
  logic [DATAWIDTH-1:0] count_d  [LANES];
  logic [DATAWIDTH-1:0] period_q [LANES];
  logic [DATAWIDTH-1:0] period_d [LANES];
  logic [SW-1:0]        slot_q, slot_d;
  logic [LANES-1:0]     shift_q, shift_d;

  // Comparator feed: the visited lane's count and period.
  assign CC_LANESCHED_cmpData_OutBUS  = count_q[slot_q];
  assign CC_LANESCHED_cmpValue_OutBUS = period_q[slot_q];
  assign CC_LANESCHED_shift_OutBUS    = shift_q;
  assign CC_LANESCHED_slot_OutBUS     = slot_q;

  // Next-state logic for the run/pause state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (CC_LANESCHED_run_InHigh) state_d = ST_SCAN;
        else                         state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (CC_LANESCHED_run_InHigh) state_d = ST_SCAN;
        else                         state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane scan datapath. The visit is qualified by run in the same cycle, not
  // by the registered state. As a result the cycle that leaves IDLE already
  // scans, and a pause of N cycles delays later strobes by exactly N cycles.
  always_comb begin
    count_d  = count_q;
    period_d = period_q;
    slot_d   = slot_q;
    shift_d  = {LANES{1'b0}};

    if (CC_LANESCHED_clear_InHigh) begin
      for (int i = 0; i < LANES; i++) begin
        count_d[i] = {DATAWIDTH{1'b0}};
      end
      slot_d = {SW{1'b0}};
    end else if (CC_LANESCHED_run_InHigh) begin
      if (period_q[slot_q] == {DATAWIDTH{1'b0}}) begin
        count_d[slot_q] = {DATAWIDTH{1'b0}};
      end else if (!CC_LANESCHED_cmpEqual_InLow) begin
        count_d[slot_q] = {DATAWIDTH{1'b0}};
        shift_d[slot_q] = 1'b1;
      end else begin
        count_d[slot_q] = count_q[slot_q] + DATAWIDTH'(1);
      end
      // LANES is a power of two, so the natural wrap of slot is the modulo.
      slot_d = slot_q + SW'(1);
    end else begin
      slot_d = slot_q;
    end

    // A period write restarts its lane. If that lane is the one being
    // visited, the write overrides the scan result and suppresses the strobe.
    if (CC_LANESCHED_cfgWrite_InHigh) begin
      period_d[CC_LANESCHED_cfgLane_InBUS] = CC_LANESCHED_cfgPeriod_InBUS;
      count_d[CC_LANESCHED_cfgLane_InBUS]  = {DATAWIDTH{1'b0}};
      shift_d[CC_LANESCHED_cfgLane_InBUS]  = 1'b0;
    end else begin
      period_d = period_d;
    end
  end

  // State registers with synchronous reset; reset drops any pending strobe.
  always_ff @(posedge CC_LANESCHED_CLOCK_50) begin
    if (CC_LANESCHED_RESET_InHigh) begin
      state_q <= ST_IDLE;
      slot_q  <= {SW{1'b0}};
      shift_q <= {LANES{1'b0}};
      for (int i = 0; i < LANES; i++) begin
        count_q[i]  <= {DATAWIDTH{1'b0}};
        period_q[i] <= {DATAWIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      for (int i = 0; i < LANES; i++) begin
        count_q[i]  <= count_d[i];
        period_q[i] <= period_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cc_lane_shift_scheduler.sv
module tb_cc_lane_shift_scheduler;

  localparam int L  = 4;
  localparam int DW = 23;
  localparam int unsigned DMASK = (32'd1 << DW) - 32'd1;

  logic          clk = 1'b0;
  logic          rst, run, clr, wr;
  logic [1:0]    lane;
  logic [DW-1:0] per;
  logic [DW-1:0] cmp_data, cmp_value;
  logic          cmp_eq_n;
  logic [L-1:0]  shift;
  logic [1:0]    slot;

  always #5 clk = ~clk;

  // Ideal external comparator.
  assign cmp_eq_n = (cmp_data == cmp_value) ? 1'b0 : 1'b1;

  cc_lane_shift_scheduler #(.LANES(L), .DATAWIDTH(DW)) dut (
    .CC_LANESCHED_CLOCK_50       (clk),
    .CC_LANESCHED_RESET_InHigh   (rst),
    .CC_LANESCHED_run_InHigh     (run),
    .CC_LANESCHED_clear_InHigh   (clr),
    .CC_LANESCHED_cfgWrite_InHigh(wr),
    .CC_LANESCHED_cfgLane_InBUS  (lane),
    .CC_LANESCHED_cfgPeriod_InBUS(per),
    .CC_LANESCHED_cmpData_OutBUS (cmp_data),
    .CC_LANESCHED_cmpValue_OutBUS(cmp_value),
    .CC_LANESCHED_cmpEqual_InLow (cmp_eq_n),
    .CC_LANESCHED_shift_OutBUS   (shift),
    .CC_LANESCHED_slot_OutBUS    (slot)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: lane bookkeeping straight from the behaviour rules.
  int unsigned m_count [L];
  int unsigned m_period[L];
  int          m_slot;
  int unsigned m_shift;

  // Values seen on the most recent sample.
  int unsigned obs_slot, obs_data, obs_value, obs_shift;

  // Strobes seen during the current scenario.
  int          sq_cyc[$];
  int unsigned sq_val[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_count[i]  = 0;
      m_period[i] = 0;
    end
    m_slot  = 0;
    m_shift = 0;
  endtask

  task automatic model_step(input bit r, input bit rn, input bit c, input bit w,
                            input int ln, input int unsigned p);
    int unsigned nsh;
    int s;
    nsh = 0;
    if (r) begin
      model_reset();
    end else begin
      if (c) begin
        for (int i = 0; i < L; i++) m_count[i] = 0;
        m_slot = 0;
        if (w) m_period[ln] = p;
      end else begin
        if (rn) begin
          s = m_slot;
          if (!(w && ln == s)) begin
            if (m_period[s] == 0) begin
              m_count[s] = 0;
            end else if (m_count[s] == m_period[s]) begin
              m_count[s] = 0;
              nsh = 32'd1 << s;
            end else begin
              m_count[s] = (m_count[s] + 1) & DMASK;
            end
          end
          m_slot = (s + 1) % L;
        end
        if (w) begin
          m_period[ln] = p;
          m_count[ln]  = 0;
        end
      end
      m_shift = nsh;
    end
  endtask

  // One clock cycle: drive, sample at the falling edge, check against the model.
  task automatic cycle(input bit r, input bit rn, input bit c, input bit w,
                       input int ln, input int unsigned p);
    rst = r; run = rn; clr = c; wr = w; lane = ln[1:0]; per = p[DW-1:0];
    @(negedge clk);
    obs_slot  = 32'(slot);
    obs_data  = 32'(cmp_data);
    obs_value = 32'(cmp_value);
    obs_shift = 32'(shift);
    chk("model_slot",  obs_slot,  m_slot);
    chk("model_data",  obs_data,  m_count[m_slot]);
    chk("model_value", obs_value, m_period[m_slot]);
    chk("model_shift", obs_shift, m_shift);
    if (shift !== '0) begin
      sq_cyc.push_back(cyc);
      sq_val.push_back(obs_shift);
    end
    model_step(r, rn, c, w, ln, p);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_scn();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc = 0;
    sq_cyc.delete();
    sq_val.delete();
  endtask

  task automatic chk_strobes(input string nm, input int n, input int c0, input int unsigned v0,
                             input int c1, input int unsigned v1, input int c2, input int unsigned v2,
                             input int c3, input int unsigned v3);
    int ec[4];
    int unsigned ev[4];
    ec = '{c0, c1, c2, c3};
    ev = '{v0, v1, v2, v3};
    chk({nm, "_count"}, sq_cyc.size(), n);
    for (int i = 0; i < n && i < sq_cyc.size(); i++) begin
      chk($sformatf("%s_cyc%0d", nm, i), sq_cyc[i], ec[i]);
      chk($sformatf("%s_val%0d", nm, i), sq_val[i], ev[i]);
    end
  endtask

  typedef struct {
    bit rst, run, clr, wr;
    int lane;
    int unsigned per;
    int unsigned e_slot, e_data, e_value, e_shift;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Expectations are what is seen during the cycle, before its clock edge.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3, 0, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1, 1, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 3, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 2, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 7, 1, 0, 3, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 2, 0, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; run = 1'b0; clr = 1'b0; wr = 1'b0; lane = 2'd0; per = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].rst, tbl[i].run, tbl[i].clr, tbl[i].wr, tbl[i].lane, tbl[i].per);
      chk($sformatf("tbl%0d_slot", i),  obs_slot,  tbl[i].e_slot);
      chk($sformatf("tbl%0d_data", i),  obs_data,  tbl[i].e_data);
      chk($sformatf("tbl%0d_value", i), obs_value, tbl[i].e_value);
      chk($sformatf("tbl%0d_shift", i), obs_shift, tbl[i].e_shift);
    end

    // No configuration: slot walks, comparator buses stay zero, no strobes.
    begin_scn();
    for (int k = 0; k < 100; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      chk("idle_slot", obs_slot, k % L);
      chk("idle_data", obs_data, 0);
      chk("idle_value", obs_value, 0);
    end
    chk_strobes("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lane 1 period 2: strobes at 10, 22, 34.
    begin_scn();
    for (int k = 0; k < 40; k++) cycle(1'b0, 1'b1, 1'b0, (k == 0), 1, 2);
    chk_strobes("cfg", 3, 10, 2, 22, 2, 34, 2, 0, 0);

    // Pause for cycles 15..21: strobe moves from 22 to 29, slot holds at 3.
    begin_scn();
    for (int k = 0; k < 45; k++) begin
      cycle(1'b0, !(k >= 15 && k <= 21), 1'b0, (k == 0), 1, 2);
      if (k >= 15 && k <= 22) chk("pause_slot", obs_slot, 3);
    end
    chk_strobes("pause", 3, 10, 2, 29, 2, 41, 2, 0, 0);

    // Rewrite lane 1 to period 5 on its matching cycle 9: next strobe at 34.
    begin_scn();
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b1, 1'b0, (k == 0 || k == 9), 1, (k == 9) ? 5 : 2);
      if (k == 9)  chk("coll_match_data", obs_data, 2);
      if (k == 13) chk("coll_count_zero", obs_data, 0);
    end
    chk_strobes("coll", 1, 34, 2, 0, 0, 0, 0, 0, 0);

    // Lanes 0 and 3 period 1, clear at cycle 6.
    begin_scn();
    for (int k = 0; k < 25; k++) begin
      cycle(1'b0, 1'b1, (k == 6), (k <= 1), (k == 0) ? 0 : 3, 1);
      if (k == 7) begin
        chk("clr_slot", obs_slot, 0);
        chk("clr_data", obs_data, 0);
        chk("clr_period_kept", obs_value, 1);
      end
    end
    chk_strobes("clr", 4, 12, 1, 15, 8, 20, 1, 23, 8);

    // Reset on the cycle lane 1 matches: strobe dropped, lanes silent.
    begin_scn();
    for (int k = 0; k < 31; k++) begin
      cycle((k == 9), 1'b1, 1'b0, (k == 0), 1, 2);
      if (k == 9) chk("rst_match_value", obs_value, 2);
      if (k == 10) chk("rst_slot", obs_slot, 0);
      if (k >= 10) chk("rst_value", obs_value, 0);
    end
    chk_strobes("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom % 500) == 0, ($urandom % 8) != 0, ($urandom % 64) == 0,
            ($urandom % 6) == 0, $urandom % L, $urandom % 5);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_lane_shift_scheduler.md
Name: cc_lane_shift_scheduler

Overview:
- Time-multiplexes one shared CC_SHIFTCOMPARATOR instance between LANES lane counters in the Frogger lane engine.
- Each lane (car/log row) has a programmable period. When a lane's counter matches its period, the block emits a one-cycle shift strobe to that lane's shift register.
- The comparator stays external. This block drives its two input buses and samples its active-low equal output.

Parameters:
- LANES, 4, number of lanes sharing the comparator; power of two, 2..16.
- DATAWIDTH, 23, counter/period width; equals the comparator's SHIFTCOMPARATOR_DATAWIDTH.

Ports:
- CC_LANESCHED_CLOCK_50  input  1  system clock; all state updates on rising edge.
- CC_LANESCHED_RESET_InHigh  input  1  synchronous, active-high reset.
- CC_LANESCHED_run_InHigh  input  1  1 = scan lanes, 0 = pause.
- CC_LANESCHED_clear_InHigh  input  1  level restart: zero all counters, slot to 0.
- CC_LANESCHED_cfgWrite_InHigh  input  1  period write strobe.
- CC_LANESCHED_cfgLane_InBUS  input  log2(LANES)  lane addressed by the write.
- CC_LANESCHED_cfgPeriod_InBUS  input  DATAWIDTH  new period; 0 = lane disabled.
- CC_LANESCHED_cmpData_OutBUS  output  DATAWIDTH  to comparator data_InBUS: count[slot].
- CC_LANESCHED_cmpValue_OutBUS  output  DATAWIDTH  to comparator SHIFT_VALUE: period[slot].
- CC_LANESCHED_cmpEqual_InLow  input  1  comparator T0_OutLow; 0 = equal.
- CC_LANESCHED_shift_OutBUS  output  LANES  per-lane one-cycle shift strobes, registered.
- CC_LANESCHED_slot_OutBUS  output  log2(LANES)  lane currently being compared.

Behaviour:
- Reset (synchronous, priority over everything):
  - all count[i] = 0 and all period[i] = 0 (all lanes disabled).
  - slot = 0, state = IDLE, shift_OutBUS = 0.
  - cmpData and cmpValue outputs are therefore 0.
- cmpData/cmpValue are combinational muxes of count[slot]/period[slot]. The comparator is combinational, so cmpEqual_InLow is sampled in the same cycle.
- FSM states:
  - IDLE: counters and slot hold; shift = 0. Go to SCAN when run = 1.
  - SCAN: one lane per cycle. Go to IDLE when run = 0; the run = 0 cycle performs no update.
- SCAN cycle on lane s = slot:
  - if period[s] = 0: count[s] = 0, no strobe.
  - else if cmpEqual_InLow = 0: count[s] = 0 and shift[s] = 1 next cycle.
  - else count[s] = count[s] + 1, modulo 2^DATAWIDTH.
  - Then slot = (s + 1) mod LANES.
- Timing:
  - Strobe latency: one cycle after the matching compare cycle.
  - shift_OutBUS is one-hot or zero and never held longer than one cycle.
  - Steady-state strobe period for lane i = (period[i] + 1) * LANES cycles while run stays high.
- Pause: strobes already registered still appear once. Resume continues from the held slot with held counts. Each paused cycle delays subsequent strobes by exactly one cycle.
- Config write (any state):
  - period[lane] = cfgPeriod and count[lane] = 0.
  - If the written lane is the current slot, the write overrides that cycle's scan update and no strobe is generated.
  - Other lanes scan normally in the same cycle.
- Clear:
  - all count = 0, slot = 0, no strobes generated that cycle; periods are kept.
  - With a simultaneous cfgWrite, the period is still written.
  - Clear beats scan; reset beats clear.
- Count wrap: a count cannot exceed a nonzero period because every period write clears the count. Modulo wrap is defined only for robustness.
- Reset mid-operation: everything returns to reset values on the next edge. Any pending strobe is dropped.

Test Plan:
1. Reset, then run = 1 for 100 cycles with no config: shift_OutBUS stays 0; slot cycles 0,1,2,3; cmpData = cmpValue = 0 throughout.
2. Config:
   - Stimulus: write lane1 period = 2 with slot = 0 at cycle 0, run = 1.
   - Required: lane1 compares at cycles 1, 5, 9; shift[1] pulses at cycle 10, then every 12 cycles (22, 34); no other lane strobes.
3. Pause:
   - Stimulus: as in scenario 2, drop run for 7 cycles starting cycle 15.
   - Required: no strobes while paused; next shift[1] at cycle 29 instead of 22; slot frozen at its cycle-15 value.
4. Config collision:
   - Stimulus: rewrite lane1 period = 5 in the exact cycle lane1 matches with count = 2.
   - Required: no strobe at cycle +1; count[1] = 0; next strobe after 6 visits (24 cycles).
5. Clear:
   - Stimulus: lanes 0 and 3 with period = 1; assert clear mid-count.
   - Required: slot = 0 and all counts 0 next cycle; periods kept; strobes resume on the fresh schedule (shift[0] at 5 cycles after clear, then every 8).
6. Reset mid-operation:
   - Stimulus: assert reset in the cycle a match is sampled.
   - Required: no strobe next cycle; all counts, periods and slot = 0; lanes stay silent until reconfigured.
